// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM family: read-during-write
// mode encodings, the clear-sequencer state type and a byte-lane width helper.
package ram_pkg;

  // Same-address read-during-write behaviour selectors
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Clear sequencer states: CLEAR sweeps zeros through memory, RUN serves the ports
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Number of byte lanes in a word of the given width
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: after reset or a clr request it walks every address once,
// issuing a zero-write strobe per cycle, and reports busy until the sweep ends.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // Counter is one bit wider than the address so the final index is representable
  // independently of the wrap point.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  // Next-state and sweep outputs; leaving CLEAR happens on the cycle that writes DEPTH-1
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_we    = 1'b0;
    clr_addr  = cnt_q[ADDR_W-1:0];
    init_busy = 1'b0;
    case (state_q)
      CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, an optional output register and a built-in zeroing sweep.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = be_width(DATA_W);

  logic                 clr_we;
  logic [ADDR_W-1:0]    clr_addr;

  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic                 wr_accept;
  logic                 rd_accept;
  logic                 collide;
  logic [DATA_W-1:0]    old_word;
  logic [DATA_W-1:0]    merged_word;
  logic [DATA_W-1:0]    rd_word;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;

  logic [DATA_W-1:0]    s1_data_q;
  logic [DATA_W-1:0]    s1_data_d;
  logic                 s1_valid_q;
  logic                 s1_valid_d;

  ram_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // Port acceptance: a clr cycle already belongs to the sweep that follows,
  // so neither port is serviced on it.
  always_comb begin
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    if (!init_busy && !clr) begin
      wr_accept = write;
      rd_accept = rd_en;
    end
  end

  // Byte-enable merge of the new data into the currently stored word
  always_comb begin
    old_word    = mem_q[wr_addr];
    merged_word = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        merged_word[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  // Memory write source: sweep zeros take the port while clearing, user writes otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = merged_word;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array; contents are defined by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read path: the array read is naturally pre-write, write-first bypasses the merged word
  always_comb begin
    collide    = wr_accept && rd_accept && (wr_addr == rd_addr);
    rd_word    = mem_q[rd_addr];
    if ((RD_MODE == WR_FIRST) && collide) begin
      rd_word = merged_word;
    end
    s1_valid_d = rd_accept;
    s1_data_d  = rd_accept ? rd_word : s1_data_q;
  end

  // First read stage register; holds its data when no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] s2_data_q;
    logic [DATA_W-1:0] s2_data_d;
    logic              s2_valid_q;
    logic              s2_valid_d;

    // A clr accepted in RUN also cancels the read sitting in the first stage
    always_comb begin
      s2_valid_d = s1_valid_q && !(clr && !init_busy);
      s2_data_d  = s2_valid_d ? s1_data_q : s2_data_q;
    end

    // Output pipeline register
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign q       = s2_data_q;
    assign q_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign q       = s1_data_q;
    assign q_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: one 8-bit read-first instance without output
// register and one 32-bit write-first instance with output register, driven in lockstep.
module tb_ram_dp_param;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        write;
  logic [5:0]  wr_addr;
  logic        rd_en;
  logic [5:0]  rd_addr;

  logic [7:0]  data_a;
  logic [0:0]  be_a;
  logic [7:0]  q_a;
  logic        qv_a;
  logic        busy_a;

  logic [31:0] data_b;
  logic [3:0]  be_b;
  logic [31:0] q_b;
  logic        qv_b;
  logic        busy_b;

  int checks;
  int fails;
  int cnt;
  int bad;

  ram_dp_param #(
    .DATA_W(8), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)
  ) u_a (
    .clk(clk), .rst(rst), .clr(clr), .write(write), .wr_addr(wr_addr),
    .data(data_a), .wr_be(be_a), .rd_en(rd_en), .rd_addr(rd_addr),
    .q(q_a), .q_valid(qv_a), .init_busy(busy_a)
  );

  ram_dp_param #(
    .DATA_W(32), .ADDR_W(6), .RD_MODE(1), .OUT_REG(1)
  ) u_b (
    .clk(clk), .rst(rst), .clr(clr), .write(write), .wr_addr(wr_addr),
    .data(data_b), .wr_be(be_b), .rd_en(rd_en), .rd_addr(rd_addr),
    .q(q_b), .q_valid(qv_b), .init_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a write to both instances with separate data/enables
  task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] da, input logic ba,
                               input logic [31:0] db, input logic [3:0] bb);
    write   = 1'b1;
    wr_addr = addr;
    data_a  = da;
    be_a    = ba;
    data_b  = db;
    be_b    = bb;
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    rst     = 1'b1;
    clr     = 1'b0;
    write   = 1'b0;
    wr_addr = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    data_a  = '0;
    be_a    = '0;
    data_b  = '0;
    be_b    = '0;

    tick(); tick(); tick();
    checkOutput("rst_q_a", {24'h0, q_a}, 32'h0);
    checkOutput("rst_qv_a", {31'h0, qv_a}, 32'h0);
    checkOutput("rst_busy_a", {31'h0, busy_a}, 32'h1);
    checkOutput("rst_q_b", q_b, 32'h0);
    checkOutput("rst_qv_b", {31'h0, qv_b}, 32'h0);

    // Sweep after reset: busy for exactly 64 cycles
    rst = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("sweep_len", cnt, 64);
    checkOutput("sweep_busy_b", {31'h0, busy_b}, 32'h0);

    // Read 0, 1, 63 back-to-back after the sweep
    rd_en = 1'b1; rd_addr = 6'd0;
    tick();
    checkOutput("rd0_qv_a", {31'h0, qv_a}, 32'h1);
    checkOutput("rd0_q_a", {24'h0, q_a}, 32'h0);
    checkOutput("rd0_qv_b_lat", {31'h0, qv_b}, 32'h0);
    rd_addr = 6'd1;
    tick();
    checkOutput("rd1_qv_a", {31'h0, qv_a}, 32'h1);
    checkOutput("rd0_qv_b", {31'h0, qv_b}, 32'h1);
    rd_addr = 6'd63;
    tick();
    checkOutput("rd63_q_a", {24'h0, q_a}, 32'h0);
    checkOutput("rd63_qv_a", {31'h0, qv_a}, 32'h1);
    rd_en = 1'b0;
    tick();
    checkOutput("rd_idle_qv_a", {31'h0, qv_a}, 32'h0);
    checkOutput("rd63_qv_b", {31'h0, qv_b}, 32'h1);
    checkOutput("rd63_q_b", q_b, 32'h0);
    tick();
    checkOutput("rd_idle_qv_b", {31'h0, qv_b}, 32'h0);

    // Basic writes then back-to-back reads
    applyStimulus(6'd0, 8'h01, 1'b1, 32'h0000_0001, 4'hF); tick();
    applyStimulus(6'd1, 8'h02, 1'b1, 32'h0000_0002, 4'hF); tick();
    applyStimulus(6'd3, 8'h03, 1'b1, 32'h0000_0003, 4'hF); tick();
    write = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd0;
    tick();
    checkOutput("basic0_q_a", {24'h0, q_a}, 32'h01);
    rd_addr = 6'd1;
    tick();
    checkOutput("basic1_q_a", {24'h0, q_a}, 32'h02);
    checkOutput("basic0_q_b", q_b, 32'h1);
    rd_addr = 6'd3;
    tick();
    checkOutput("basic3_q_a", {24'h0, q_a}, 32'h03);
    checkOutput("basic3_qv_a", {31'h0, qv_a}, 32'h1);
    checkOutput("basic1_q_b", q_b, 32'h2);
    rd_en = 1'b0;
    tick();
    checkOutput("basic_hold_q_a", {24'h0, q_a}, 32'h03);
    checkOutput("basic_hold_qv_a", {31'h0, qv_a}, 32'h0);
    checkOutput("basic3_q_b", q_b, 32'h3);
    tick();
    checkOutput("basic_hold_q_b", q_b, 32'h3);

    // Byte enables: full write then partial overwrite (instance a sees wr_be=0)
    applyStimulus(6'd5, 8'hDD, 1'b1, 32'hAABB_CCDD, 4'hF); tick();
    applyStimulus(6'd5, 8'h44, 1'b0, 32'h1122_3344, 4'b0101); tick();
    write = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd5;
    tick();
    rd_en = 1'b0;
    checkOutput("be_zero_noop_a", {24'h0, q_a}, 32'hDD);
    tick();
    checkOutput("be_merge_b", q_b, 32'hAA22_CC44);

    // Collision: a is read-first, b is write-first with a partial byte mask
    applyStimulus(6'd7, 8'h11, 1'b1, 32'h1111_1111, 4'hF); tick();
    applyStimulus(6'd7, 8'h5A, 1'b1, 32'h5A5A_5A5A, 4'b0011);
    rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    checkOutput("coll_rdfirst_a", {24'h0, q_a}, 32'h11);
    write = 1'b0;
    tick();
    rd_en = 1'b0;
    checkOutput("coll_after_a", {24'h0, q_a}, 32'h5A);
    checkOutput("coll_wrfirst_b", q_b, 32'h1111_5A5A);
    tick();
    checkOutput("coll_after_b", q_b, 32'h1111_5A5A);

    // Output register latency: read@1 appears only after the second edge
    rd_en = 1'b1; rd_addr = 6'd1;
    tick();
    rd_en = 1'b0;
    checkOutput("oreg_n_qv_b", {31'h0, qv_b}, 32'h0);
    checkOutput("oreg_n_q_b", q_b, 32'h1111_5A5A);
    tick();
    checkOutput("oreg_n1_qv_b", {31'h0, qv_b}, 32'h1);
    checkOutput("oreg_n1_q_b", q_b, 32'h2);

    // Reset while a read is in the pipeline
    rd_en = 1'b1; rd_addr = 6'd3;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    checkOutput("rstmid_qv_b", {31'h0, qv_b}, 32'h0);
    checkOutput("rstmid_q_b", q_b, 32'h0);
    checkOutput("rstmid_q_a", {24'h0, q_a}, 32'h0);
    checkOutput("rstmid_busy_a", {31'h0, busy_a}, 32'h1);
    rst = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 200) begin
      cnt++;
      tick();
    end
    checkOutput("resweep_len", cnt, 64);

    // clr in RUN: write FF@10, confirm, then clear with traffic ignored
    applyStimulus(6'd10, 8'hFF, 1'b1, 32'hFFFF_FFFF, 4'hF); tick();
    write = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd10;
    tick();
    checkOutput("pre_clr_q_a", {24'h0, q_a}, 32'hFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_busy_a", {31'h0, busy_a}, 32'h1);
    checkOutput("clr_drop_qv_a", {31'h0, qv_a}, 32'h0);
    checkOutput("clr_kill_qv_b", {31'h0, qv_b}, 32'h0);
    applyStimulus(6'd10, 8'h77, 1'b1, 32'h7777_7777, 4'hF);
    rd_en = 1'b1; rd_addr = 6'd10;
    cnt = 0;
    bad = 0;
    while (busy_a && cnt < 200) begin
      if (qv_a || qv_b) bad = 1;
      cnt++;
      tick();
    end
    write = 1'b0;
    rd_en = 1'b0;
    checkOutput("clr_sweep_len", cnt, 64);
    checkOutput("clr_ports_ignored", bad, 0);
    rd_en = 1'b1; rd_addr = 6'd10;
    tick();
    rd_en = 1'b0;
    checkOutput("post_clr_q_a", {24'h0, q_a}, 32'h00);
    checkOutput("post_clr_qv_a", {31'h0, qv_a}, 32'h1);
    tick();
    checkOutput("post_clr_q_b", q_b, 32'h0);
    checkOutput("post_clr_qv_b", {31'h0, qv_b}, 32'h1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
